// File: rtl/prog_loader_if.sv
// Byte-stream handshake plus program-memory write bus for prog_loader.
//   byte_valid/byte_data : stream source -> loader
//   byte_ready           : loader -> stream source
//   mem_we/addr/wdata    : loader -> program memory write port
// master = stream source / memory side (the environment), slave = the loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 14
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Program-memory loader: parses a framed byte stream
//   [len_hi][len_lo] { [word_hi][word_lo] } x len [checksum]
// and writes one 14-bit instruction word per pair of data bytes into the
// CPU program memory, holding the CPU in reset while a frame is in flight.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle pulse that opens a frame (honoured only in IDLE)
//   bus          : byte stream handshake + memory write port (slave side)
//   cpu_hold     : CPU reset request, high from start until frame end/abort
//   busy         : loader not idle
//   done         : one-cycle pulse, frame loaded with a matching checksum
//   err_len/fmt/chk : sticky error flags, cleared by the next accepted start
//   word_count   : words written in the current or last frame
module prog_loader #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 14,
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  prog_loader_if.slave   bus,
  output logic           cpu_hold,
  output logic           busy,
  output logic           done,
  output logic           err_len,
  output logic           err_fmt,
  output logic           err_chk,
  output logic [11:0]    word_count
);

  localparam int unsigned LEN_W = 12;
  localparam int unsigned HI_W  = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_WRITE,
    S_CHK
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [7:0]        chk;
  logic [HI_W-1:0]   hi;

  logic              xfer_c;
  logic [LEN_W-1:0]  len_new_c;
  logic              len_bad_c;
  logic [LEN_W-1:0]  wc_next_c;

  // A byte moves only when both sides agree on the same edge.
  assign xfer_c    = bus.byte_valid && bus.byte_ready;

  // Length as it will be once the low length byte lands this cycle.
  assign len_new_c = {len[LEN_W-1:8], bus.byte_data};
  assign len_bad_c = (len_new_c == '0) || (32'(len_new_c) > DEPTH);

  assign wc_next_c = word_count + LEN_W'(1);

  // Frame sequencer; every output is a register updated alongside state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= ADDR_W'(BASE_ADDR);
      bus.mem_wdata  <= '0;
      cpu_hold       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_len        <= 1'b0;
      err_fmt        <= 1'b0;
      err_chk        <= 1'b0;
      word_count     <= '0;
      len            <= '0;
      chk            <= '0;
      hi             <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      bus.mem_we <= 1'b0;
      done       <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_LEN_HI;
            bus.byte_ready <= 1'b1;
            busy           <= 1'b1;
            cpu_hold       <= 1'b1;
            err_len        <= 1'b0;
            err_fmt        <= 1'b0;
            err_chk        <= 1'b0;
            word_count     <= '0;
            bus.mem_addr   <= ADDR_W'(BASE_ADDR);
            chk            <= '0;
          end
        end

        S_LEN_HI: begin
          // Only the low nibble carries length; the rest is ignored.
          if (xfer_c) begin
            len[LEN_W-1:8] <= bus.byte_data[3:0];
            state          <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (xfer_c) begin
            len[7:0] <= bus.byte_data;
            if (len_bad_c) begin
              err_len        <= 1'b1;
              cpu_hold       <= 1'b0;
              busy           <= 1'b0;
              bus.byte_ready <= 1'b0;
              state          <= S_IDLE;
            end else begin
              state <= S_DAT_HI;
            end
          end
        end

        S_DAT_HI: begin
          // Upper byte may only use bits 5:0 of a 14-bit word.
          if (xfer_c) begin
            if (bus.byte_data[7:6] != 2'b00) begin
              err_fmt        <= 1'b1;
              cpu_hold       <= 1'b0;
              busy           <= 1'b0;
              bus.byte_ready <= 1'b0;
              state          <= S_IDLE;
            end else begin
              hi    <= bus.byte_data[HI_W-1:0];
              chk   <= chk ^ bus.byte_data;
              state <= S_DAT_LO;
            end
          end
        end

        S_DAT_LO: begin
          // Word complete: present it and stall the stream for the write cycle.
          if (xfer_c) begin
            bus.mem_wdata  <= DATA_W'({hi, bus.byte_data});
            chk            <= chk ^ bus.byte_data;
            bus.mem_we     <= 1'b1;
            bus.byte_ready <= 1'b0;
            state          <= S_WRITE;
          end
        end

        S_WRITE: begin
          // Address wraps naturally at the memory size.
          bus.mem_addr   <= bus.mem_addr + ADDR_W'(1);
          word_count     <= wc_next_c;
          bus.byte_ready <= 1'b1;
          state          <= (wc_next_c == len) ? S_CHK : S_DAT_HI;
        end

        S_CHK: begin
          if (xfer_c) begin
            if (bus.byte_data == chk) begin
              done <= 1'b1;
            end else begin
              err_chk <= 1'b1;
            end
            cpu_hold       <= 1'b0;
            busy           <= 1'b0;
            bus.byte_ready <= 1'b0;
            state          <= S_IDLE;
          end
        end

        default: begin
          // Unreachable encoding: park safely and release the CPU.
          cpu_hold       <= 1'b0;
          busy           <= 1'b0;
          bus.byte_ready <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a frame-level model turns each byte
// frame into the list of expected memory writes and final flags; a per-cycle
// monitor checks every write strobe and done pulse against that list.
module tb_prog_loader;

  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned DATA_W    = 14;
  localparam int unsigned DEPTH     = 2048;
  localparam int unsigned BASE_ADDR = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cpu_hold, busy, done, err_len, err_fmt, err_chk;
  logic [11:0] word_count;

  prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  prog_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bif.slave),
    .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .err_len(err_len), .err_fmt(err_fmt), .err_chk(err_chk),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done = 0;
  bit  exp_err_len, exp_err_fmt, exp_err_chk;
  int  exp_wc;
  int  n_used;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame-level model: interpret the byte list by the framing rules.
  task automatic model_frame(input logic [7:0] fr[$]);
    int         len;
    logic [7:0] c;
    logic [7:0] h;
    exp_err_len = 0; exp_err_fmt = 0; exp_err_chk = 0;
    exp_wc = 0; c = 8'h00;
    len = int'(fr[0] & 8'h0F) * 256 + int'(fr[1]);
    if (len == 0 || len > int'(DEPTH)) begin
      exp_err_len = 1; n_used = 2;
      return;
    end
    for (int i = 0; i < len; i++) begin
      h = fr[2 + 2*i];
      if (h >= 8'h40) begin
        exp_err_fmt = 1; n_used = 3 + 2*i;
        return;
      end
      exp_wr.push_back('{a: ADDR_W'((BASE_ADDR + i) % (1 << ADDR_W)),
                         d: DATA_W'(int'(h) * 256 + int'(fr[3 + 2*i]))});
      c = c ^ h ^ fr[3 + 2*i];
      exp_wc++;
    end
    n_used = 2 + 2*len + 1;
    if (fr[2 + 2*len] == c) exp_done++;
    else exp_err_chk = 1;
  endtask

  // Per-cycle monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bif.mem_we) begin
      check("write_expected", 32'(exp_wr.size() > 0), 32'd1);
      if (exp_wr.size() > 0) begin
        check("mem_addr", 32'(bif.mem_addr), 32'(exp_wr[0].a));
        check("mem_wdata", 32'(bif.mem_wdata), 32'(exp_wr[0].d));
        void'(exp_wr.pop_front());
      end
    end
    if (done) begin
      check("done_expected", 32'(exp_done > 0), 32'd1);
      check("hold_falls_with_done", 32'(cpu_hold), 32'd0);
      if (exp_done > 0) exp_done--;
    end
    if (done || bif.mem_we) check("done_we_exclusive", 32'(done & bif.mem_we), 32'd0);
    if (!busy) check("ready_low_when_idle", 32'(bif.byte_ready), 32'd0);
  end

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int budget;
    bit sent;
    budget = 300; sent = 0;
    while (!sent && budget > 0) begin
      @(negedge clk);
      if (gappy && $urandom_range(0, 2) == 0) begin
        bif.byte_valid = 1'b0;
        start = ($urandom_range(0, 1) == 1);
      end else begin
        start = 1'b0;
        bif.byte_valid = 1'b1;
        bif.byte_data  = b;
        if (bif.byte_ready) begin
          @(posedge clk);
          #1;
          bif.byte_valid = 1'b0;
          sent = 1;
        end
      end
      budget--;
    end
    start = 1'b0;
    if (!sent) begin
      bif.byte_valid = 1'b0;
      compared++; mismatched++;
      $display("FAIL byte_accept: byte %02h not accepted, required within 300 cycles", b);
    end
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
    check({tag, "_done_left"}, 32'(exp_done), 32'd0);
    check({tag, "_err_len"}, 32'(err_len), 32'(exp_err_len));
    check({tag, "_err_fmt"}, 32'(err_fmt), 32'(exp_err_fmt));
    check({tag, "_err_chk"}, 32'(err_chk), 32'(exp_err_chk));
    check({tag, "_word_count"}, 32'(word_count), 32'(exp_wc));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check({tag, "_hold_on"}, 32'(cpu_hold), 32'd1);
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] fr[$], input bit gappy, input string tag);
    model_frame(fr);
    pulse_start(tag);
    for (int i = 0; i < n_used; i++) send_byte(fr[i], gappy);
    repeat (3) @(negedge clk);
    end_checks(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] c;

    rst = 1'b1; start = 1'b0;
    bif.byte_valid = 1'b0; bif.byte_data = 8'h00;

    // 1: reset values, and a valid byte while idle is held off.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_byte_ready", 32'(bif.byte_ready), 32'd0);
    check("rst_mem_we", 32'(bif.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bif.mem_addr), 32'(BASE_ADDR));
    check("rst_mem_wdata", 32'(bif.mem_wdata), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_errs", 32'({err_len, err_fmt, err_chk}), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    bif.byte_valid = 1'b1; bif.byte_data = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      check("idle_holdoff_ready", 32'(bif.byte_ready), 32'd0);
    end
    bif.byte_valid = 1'b0;
    check("idle_holdoff_busy", 32'(busy), 32'd0);

    // 2: two-word frame; pin the model against hand-computed values first.
    f = '{8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h01, 8'h0A};
    model_frame(f);
    check("model_n_writes", 32'(exp_wr.size()), 32'd2);
    check("model_w0", 32'(exp_wr[0].d), 32'h3005);
    check("model_w1", 32'(exp_wr[1].d), 32'h3E01);
    check("model_a1", 32'(exp_wr[1].a), 32'd1);
    check("model_done", 32'(exp_done), 32'd1);
    exp_wr.delete(); exp_done = 0;
    run_frame(f, 1'b0, "t2");
    check("t2_wc_literal", 32'(word_count), 32'd2);

    // 3: same frame with a bursty source and stray start pulses.
    run_frame(f, 1'b1, "t3");

    // 4: illegal lengths.
    f = '{8'h00, 8'h00};
    run_frame(f, 1'b0, "t4_zero");
    check("t4_zero_err_len_literal", 32'(err_len), 32'd1);
    f = '{8'h08, 8'h01};
    run_frame(f, 1'b0, "t4_2049");
    check("t4_2049_err_len_literal", 32'(err_len), 32'd1);

    // 5: bad upper byte, then bad checksum.
    f = '{8'h00, 8'h01, 8'hC0, 8'h00};
    run_frame(f, 1'b0, "t5_fmt");
    check("t5_fmt_literal", 32'(err_fmt), 32'd1);
    f = '{8'h00, 8'h01, 8'h30, 8'h05, 8'h00};
    run_frame(f, 1'b0, "t5_chk");
    check("t5_chk_literal", 32'(err_chk), 32'd1);

    // Length exactly DEPTH (upper length nibble high bits ignored: F8 -> 8).
    f = '{8'hF8, 8'h00};
    c = 8'h00;
    for (int i = 0; i < int'(DEPTH); i++) begin
      f.push_back(8'((i >> 8) & 8'h3F));
      f.push_back(8'(i * 7 + 3));
      c = c ^ 8'((i >> 8) & 8'h3F) ^ 8'(i * 7 + 3);
    end
    f.push_back(c);
    run_frame(f, 1'b0, "t_depth");

    // 6: reset while the third word's low byte is being offered.
    f = '{8'h00, 8'h05, 8'h10, 8'h01, 8'h10, 8'h02, 8'h10, 8'h03,
          8'h10, 8'h04, 8'h10, 8'h05, 8'h00};
    model_frame(f);
    pulse_start("t6");
    for (int i = 0; i < 7; i++) send_byte(f[i], 1'b0);
    @(negedge clk);
    check("t6_in_dat_lo_ready", 32'(bif.byte_ready), 32'd1);
    rst = 1'b1; bif.byte_valid = 1'b1; bif.byte_data = f[7];
    @(posedge clk); #1;
    rst = 1'b0; bif.byte_valid = 1'b0;
    @(negedge clk);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_cpu_hold", 32'(cpu_hold), 32'd0);
    check("t6_mem_we", 32'(bif.mem_we), 32'd0);
    check("t6_ready", 32'(bif.byte_ready), 32'd0);
    check("t6_writes_unissued", 32'(exp_wr.size()), 32'd3);
    exp_wr.delete(); exp_done = 0;

    f = '{8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h01, 8'h0A};
    run_frame(f, 1'b0, "t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream writer that fills the 14-bit program memory the CPU fetches from.
- The CPU only reads that memory; this block is the write side.
- Accepts a framed byte stream (length, instruction words, checksum) over a valid/ready handshake and issues one write strobe per instruction word.
- Holds the CPU in reset (cpu_hold) while a load is in progress.

Parameters:
ADDR_W, 11, program memory address width
DATA_W, 14, instruction word width (fixed 14; upper byte carries bits 13:8)
DEPTH, 2048, maximum number of words accepted in one frame
BASE_ADDR, 0, address written by the first word of every frame

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, begins a frame; ignored unless state is IDLE
byte_valid  in  1  byte_data holds a valid byte
byte_data  in  8  incoming stream byte
byte_ready  out  1  loader can accept a byte this cycle
mem_we  out  1  one-cycle program-memory write strobe
mem_addr  out  ADDR_W  write address, valid when mem_we=1
mem_wdata  out  DATA_W  write data, valid when mem_we=1
cpu_hold  out  1  high from start accept until frame end; drives CPU reset
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, frame loaded and checksum matched
err_len  out  1  sticky, length 0 or > DEPTH
err_fmt  out  1  sticky, upper byte bits 7:6 nonzero
err_chk  out  1  sticky, checksum mismatch
word_count  out  12  words written in current or last frame

Behaviour:
- Reset (rst=1 at a clock edge, any state): state=IDLE.
- Reset values: byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=0, done=0, all err_*=0, word_count=0, length and checksum registers cleared.
- Reset mid-frame abandons the frame. Words already written stay in memory.
- Handshake: a byte transfers on a clock edge where byte_valid=1 and byte_ready=1. byte_ready=1 only in states LEN_HI, LEN_LO, DAT_HI, DAT_LO and CHK; otherwise 0.
- byte_valid without byte_ready is held off and does not transfer.
- IDLE:
  - start=1 -> LEN_HI.
  - Same edge: cpu_hold<=1, clear err_*, word_count<=0, mem_addr<=BASE_ADDR, chk<=0.
- LEN_HI: on transfer, len[11:8]<=byte_data[3:0] (bits 7:4 ignored) -> LEN_LO.
- LEN_LO:
  - On transfer, len[7:0]<=byte_data.
  - If the resulting len==0 or len>DEPTH: err_len<=1, cpu_hold<=0 -> IDLE.
  - Otherwise -> DAT_HI.
- DAT_HI:
  - On transfer, if byte_data[7:6]!=0: err_fmt<=1, cpu_hold<=0 -> IDLE.
  - Otherwise hi<=byte_data[5:0], chk<=chk^byte_data -> DAT_LO.
- DAT_LO: on transfer, mem_wdata<={hi,byte_data}, chk<=chk^byte_data -> WRITE.
- WRITE (exactly one cycle, byte_ready=0):
  - mem_we=1 with mem_addr and mem_wdata stable.
  - Next edge: mem_addr<=mem_addr+1 (wraps modulo 2^ADDR_W), word_count<=word_count+1.
  - Then, if word_count+1==len -> CHK, else -> DAT_HI.
- CHK:
  - On transfer, if byte_data==chk: done<=1 (one cycle).
  - Otherwise err_chk<=1.
  - Either way cpu_hold<=0 -> IDLE.
- Latency:
  - Second data byte accepted at edge N -> mem_we high during cycle N+1.
  - Next byte_ready no earlier than cycle N+2.
  - Minimum frame time is 3+3*len+1 cycles.
- start during a non-IDLE state is ignored; it neither restarts nor aborts the frame.
- err_* flags hold until the next accepted start or rst.
- done and mem_we are never high in the same cycle.
- word_count holds its final value after a frame ends or aborts.

Test Plan:
1. rst for 2 cycles, then idle -> all outputs at reset values; byte_valid=1 with 0xAA gives byte_ready=0 and no transfer.
2. start; bytes 00 02 30 05 3E 01 0A (chk=30^05^3E^01=0A) -> mem_we at addr 0 data 0x3005, then addr 1 data 0x3E01; done pulses once; word_count=2; cpu_hold falls with done.
3. Same frame with byte_valid toggled 1/0 randomly and a start pulse mid-frame -> identical writes and done; the stray start has no effect.
4. Length bytes 00 00, and separately 08 01 (len=2049 > DEPTH) -> err_len=1, no mem_we, state IDLE, cpu_hold=0.
5. Frame len=1 with data C0 00 -> err_fmt=1, no write. Frame len=1, data 30 05, chk byte 00 -> write 0x3005 occurs, err_chk=1, done stays 0.
6. rst asserted during DAT_LO of word 3 of a 5-word frame -> next cycle: IDLE, cpu_hold=0, mem_we=0. A subsequent full frame writes from BASE_ADDR again.
